// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-port handshake signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int WDT_W  = 2
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_resp_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [WDT_W-1:0]  lsu_req_wdt;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_resp_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [WDT_W-1:0]  mem_req_wdt;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wdt,
    input  lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wdt
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wdt,
    output lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wdt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises IFU and LSU traffic onto one memory port: one transaction in flight,
// round-robin grant on contention, response routed back to the requester that issued it.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int WDT_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arbiter_if.slave bus,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [WDT_W-1:0] WDT64     = WDT_W'(3);
  localparam logic             OWNER_IFU = 1'b0;
  localparam logic             OWNER_LSU = 1'b1;

  // Handshakes: a transfer happens on a clock edge where valid and ready are both 1;
  // valid never waits on ready, and everything a valid qualifies is held until the transfer.

  state_e            state_q;
  state_e            state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WDT_W-1:0]  wdt_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_ifu;
  logic              grant_lsu;
  logic              owner_resp_ready;

  // Contention goes to whichever requester was not granted last.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        grant_lsu = (last_grant_q == OWNER_IFU);
        grant_ifu = (last_grant_q == OWNER_LSU);
      end else begin
        grant_ifu = bus.ifu_req_valid;
        grant_lsu = bus.lsu_req_valid;
      end
    end
  end

  assign owner_resp_ready = (owner_q == OWNER_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_ifu || grant_lsu) state_d = ISSUE;
      ISSUE:   if (bus.mem_req_ready)      state_d = WAIT;
      WAIT:    if (bus.mem_resp_valid)     state_d = RESP;
      RESP:    if (owner_resp_ready)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once at grant and stay frozen for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWNER_IFU;
      owner_q      <= OWNER_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wdt_q        <= '0;
    end else if (grant_lsu) begin
      last_grant_q <= OWNER_LSU;
      owner_q      <= OWNER_LSU;
      addr_q       <= bus.lsu_req_addr;
      wen_q        <= bus.lsu_req_wen;
      wdata_q      <= bus.lsu_req_wdata;
      wdt_q        <= bus.lsu_req_wdt;
    end else if (grant_ifu) begin
      last_grant_q <= OWNER_IFU;
      owner_q      <= OWNER_IFU;
      addr_q       <= bus.ifu_req_addr;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wdt_q        <= WDT64;
    end
  end

  // Stores complete with zero data; stray strobes outside WAIT are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_q == WAIT && bus.mem_resp_valid) begin
      rdata_q <= wen_q ? '0 : bus.mem_resp_rdata;
    end
  end

  always_comb begin
    bus.ifu_req_ready  = grant_ifu;
    bus.lsu_req_ready  = grant_lsu;
    bus.mem_req_valid  = (state_q == ISSUE);
    bus.mem_req_addr   = addr_q;
    bus.mem_req_wen    = wen_q;
    bus.mem_req_wdata  = wdata_q;
    bus.mem_req_wdt    = wdt_q;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_rdata = '0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_rdata = '0;
    if (state_q == RESP) begin
      if (owner_q == OWNER_LSU) begin
        bus.lsu_resp_valid = 1'b1;
        bus.lsu_resp_rdata = rdata_q;
      end else begin
        bus.ifu_resp_valid = 1'b1;
        bus.ifu_resp_rdata = rdata_q;
      end
    end
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single requesters, contention order, backpressure
// and reset in the middle of a transaction, with hand-computed expectations.
module tb_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int WDT_W  = 2;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks;
  int n_pass;
  logic [DATA_W-1:0] exp_q[$];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDT_W(WDT_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDT_W(WDT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%h required 0x%h", tag, obs, exp);
    end
  endtask

  // One transaction with memory and response side ready at first opportunity.
  // Starts at the IDLE negedge (cycle T); returns at the T+3 negedge checks.
  task automatic do_txn(input string tag, input bit v_ifu, input bit v_lsu,
                        input bit exp_lsu, input logic [63:0] mem_data, input bit keep);
    logic [ADDR_W-1:0] e_addr;
    logic              e_wen;
    logic [DATA_W-1:0] e_wdata;
    logic [WDT_W-1:0]  e_wdt;
    logic [DATA_W-1:0] e_rdata;

    @(negedge clk);
    bus.ifu_req_valid = v_ifu;
    bus.lsu_req_valid = v_lsu;
    #1;
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    check({tag, ".ifu_ready"}, 64'(bus.ifu_req_ready), 64'(!exp_lsu));
    check({tag, ".lsu_ready"}, 64'(bus.lsu_req_ready), 64'(exp_lsu));
    e_addr  = exp_lsu ? bus.lsu_req_addr  : bus.ifu_req_addr;
    e_wen   = exp_lsu ? bus.lsu_req_wen   : 1'b0;
    e_wdata = exp_lsu ? bus.lsu_req_wdata : 64'd0;
    e_wdt   = exp_lsu ? bus.lsu_req_wdt   : 2'd3;
    e_rdata = (exp_lsu && bus.lsu_req_wen) ? 64'd0 : mem_data;

    @(negedge clk);
    if (!keep) begin
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
    end
    #1;
    check({tag, ".issue_state"}, 64'(dbg_state), 64'd1);
    check({tag, ".mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, ".mem_req_addr"}, 64'(bus.mem_req_addr), 64'(e_addr));
    check({tag, ".mem_req_wen"}, 64'(bus.mem_req_wen), 64'(e_wen));
    check({tag, ".mem_req_wdata"}, 64'(bus.mem_req_wdata), 64'(e_wdata));
    check({tag, ".mem_req_wdt"}, 64'(bus.mem_req_wdt), 64'(e_wdt));
    check({tag, ".busy_ready"}, 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'd0);

    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = mem_data;
    exp_q.push_back(e_rdata);
    #1;
    check({tag, ".wait_state"}, 64'(dbg_state), 64'd2);
    check({tag, ".wait_req_valid"}, 64'(bus.mem_req_valid), 64'd0);

    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'd0;
    #1;
    e_rdata = exp_q.pop_front();
    if (exp_lsu) begin
      check({tag, ".lsu_resp_valid"}, 64'(bus.lsu_resp_valid), 64'd1);
      check({tag, ".lsu_resp_rdata"}, 64'(bus.lsu_resp_rdata), 64'(e_rdata));
      check({tag, ".ifu_resp_valid"}, 64'(bus.ifu_resp_valid), 64'd0);
    end else begin
      check({tag, ".ifu_resp_valid"}, 64'(bus.ifu_resp_valid), 64'd1);
      check({tag, ".ifu_resp_rdata"}, 64'(bus.ifu_resp_rdata), 64'(e_rdata));
      check({tag, ".lsu_resp_valid"}, 64'(bus.lsu_resp_valid), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"}, 64'(dbg_state), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({tag, ".mem_req_addr"}, 64'(bus.mem_req_addr), 64'd0);
    check({tag, ".mem_req_fields"},
          64'({bus.mem_req_wen, bus.mem_req_wdt}) | 64'(bus.mem_req_wdata), 64'd0);
    check({tag, ".resp_valid"}, 64'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 64'd0);
    check({tag, ".resp_rdata"}, 64'(bus.ifu_resp_rdata) | 64'(bus.lsu_resp_rdata), 64'd0);
    check({tag, ".req_ready"}, 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wdt    = '0;
    bus.lsu_resp_ready = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // IFU alone
    bus.ifu_req_addr = 64'h0000_0000_8000_0000;
    do_txn("ifu_only", 1'b1, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 1'b0);

    // LSU store alone
    bus.lsu_req_addr  = 64'h0000_0000_8000_1004;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wdata = 64'h0000_0000_DEAD_BEEF;
    bus.lsu_req_wdt   = 2'd2;
    do_txn("lsu_store", 1'b0, 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b0);

    // contention from a fresh reset: LSU, IFU, LSU, IFU
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.ifu_req_addr  = 64'h1000;
    bus.lsu_req_addr  = 64'h2000;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wdata = 64'h55;
    bus.lsu_req_wdt   = 2'd1;
    do_txn("cont1", 1'b1, 1'b1, 1'b1, 64'hA1A1, 1'b1);
    do_txn("cont2", 1'b1, 1'b1, 1'b0, 64'hB2B2, 1'b1);
    do_txn("cont3", 1'b1, 1'b1, 1'b1, 64'hC3C3, 1'b1);
    do_txn("cont4", 1'b1, 1'b1, 1'b0, 64'hD4D4, 1'b0);

    // backpressure on both the memory request and the LSU response
    bus.lsu_req_addr  = 64'h3008;
    bus.lsu_req_wdata = 64'hA5A5;
    bus.lsu_req_wdt   = 2'd1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    #1;
    check("bp.lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      bus.mem_resp_valid = (i == 2);
      bus.mem_resp_rdata = 64'hBAD;
      #1;
      check("bp.issue_state", 64'(dbg_state), 64'd1);
      check("bp.mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
      check("bp.mem_req_addr", 64'(bus.mem_req_addr), 64'h3008);
      check("bp.mem_req_wdata", 64'(bus.mem_req_wdata), 64'hA5A5);
      check("bp.mem_req_wdt", 64'(bus.mem_req_wdt), 64'd1);
      check("bp.ifu_ready_issue", 64'(bus.ifu_req_ready), 64'd0);
    end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b1;
    #1;
    check("bp.stray_ignored", 64'(dbg_state), 64'd1);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'hCAFE_F00D;
    bus.lsu_resp_ready = 1'b0;
    #1;
    check("bp.wait_state", 64'(dbg_state), 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = 64'h0;
      #1;
      check("bp.lsu_resp_valid", 64'(bus.lsu_resp_valid), 64'd1);
      check("bp.lsu_resp_rdata", 64'(bus.lsu_resp_rdata), 64'hCAFE_F00D);
      check("bp.ifu_ready_resp", 64'(bus.ifu_req_ready), 64'd0);
      check("bp.ifu_resp_valid", 64'(bus.ifu_resp_valid), 64'd0);
    end
    @(negedge clk);
    bus.lsu_resp_ready = 1'b1;
    #1;
    check("bp.resp_held", 64'(bus.lsu_resp_valid), 64'd1);
    @(negedge clk);
    #1;
    check("bp.back_idle", 64'(busy), 64'd0);
    check("bp.ifu_granted", 64'(bus.ifu_req_ready), 64'd1);
    bus.ifu_req_valid = 1'b0;

    // reset while an IFU fetch sits in WAIT
    bus.ifu_req_addr = 64'h8000_0040;
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_wait.pre_state", 64'(dbg_state), 64'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h1234;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    check("rst_wait.stray_idle", 64'(dbg_state), 64'd0);
    check("rst_wait.no_resp", 64'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 64'd0);
    bus.lsu_req_addr = 64'h4000;
    bus.lsu_req_wen  = 1'b0;
    do_txn("rst_wait.cont", 1'b1, 1'b1, 1'b1, 64'h7777, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
